// File: rtl/serial_bus_bridge_pkg.sv
// Shared constants for the UART-to-bus bridge: frame opcodes, response bytes
// and FSM state encodings.
package serial_bus_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] ST_ACK   = 8'h06;
    localparam logic [7:0] ST_NAK   = 8'h15;

    localparam logic [2:0] S_CMD     = 3'd0;
    localparam logic [2:0] S_ADR_HI  = 3'd1;
    localparam logic [2:0] S_ADR_LO  = 3'd2;
    localparam logic [2:0] S_DAT_HI  = 3'd3;
    localparam logic [2:0] S_DAT_LO  = 3'd4;
    localparam logic [2:0] S_BUS     = 3'd5;
    localparam logic [2:0] S_TX_LOAD = 3'd6;
    localparam logic [2:0] S_TX_WAIT = 3'd7;

endpackage

// File: rtl/bridge_timeout_counter.sv
// Saturating 32-bit cycle counter; expired is raised in the LIMIT-th enabled
// cycle since the last clear.
module bridge_timeout_counter #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [31:0] LAST = 32'(LIMIT - 1);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != '1) begin
            count <= count + 32'd1;
        end
    end

    assign expired = enable && !clear && (count >= LAST);

endmodule

// File: rtl/serial_bus_bridge.sv
// Decodes fixed-length binary frames from the UART, runs one 16-bit bus
// read/write and streams the status/data response back to the UART.
module serial_bus_bridge
    import serial_bus_bridge_pkg::*;
#(
    parameter int BUS_TIMEOUT  = 1023,
    parameter int BYTE_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_dstrb_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_dstrb_o,
    input  logic        tx_busy_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        frame_err_o
);

    logic [2:0]  state;
    logic [7:0]  opcode;
    logic [7:0]  adr_hi_q;
    logic [7:0]  adr_lo_q;
    logic [7:0]  dat_hi_q;
    logic [7:0]  status;
    logic [15:0] rd_data;
    logic [1:0]  byte_idx;
    logic [1:0]  resp_last;
    logic [1:0]  tx_hold;
    logic [7:0]  resp_byte;
    logic        in_frame;
    logic        in_bus;
    logic        gap_expired;
    logic        bus_expired;

    assign in_frame = (state == S_ADR_HI) || (state == S_ADR_LO) ||
                      (state == S_DAT_HI) || (state == S_DAT_LO);
    assign in_bus   = (state == S_BUS);

    bridge_timeout_counter #(.LIMIT(BYTE_TIMEOUT)) u_gap_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_dstrb_i || !in_frame),
        .enable  (in_frame),
        .expired (gap_expired)
    );

    bridge_timeout_counter #(.LIMIT(BUS_TIMEOUT)) u_bus_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_bus),
        .enable  (in_bus),
        .expired (bus_expired)
    );

    always_comb begin
        resp_byte = status;
        case (byte_idx)
            2'd1:    resp_byte = rd_data[15:8];
            2'd2:    resp_byte = rd_data[7:0];
            default: resp_byte = status;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_CMD;
            tx_data_o   <= '0;
            tx_dstrb_o  <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            frame_err_o <= 1'b0;
            byte_idx    <= '0;
            resp_last   <= '0;
            tx_hold     <= '0;
        end else begin
            tx_dstrb_o  <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                S_CMD: begin
                    if (rx_dstrb_i) begin
                        opcode    <= rx_data_i;
                        byte_idx  <= '0;
                        resp_last <= '0;
                        if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
                            state <= S_ADR_HI;
                        end else begin
                            status      <= ST_NAK;
                            frame_err_o <= 1'b1;
                            state       <= S_TX_LOAD;
                        end
                    end
                end
                S_ADR_HI: begin
                    if (rx_dstrb_i) begin
                        adr_hi_q <= rx_data_i;
                        state    <= S_ADR_LO;
                    end else if (gap_expired) begin
                        frame_err_o <= 1'b1;
                        state       <= S_CMD;
                    end
                end
                S_ADR_LO: begin
                    if (rx_dstrb_i) begin
                        adr_lo_q <= rx_data_i;
                        if (opcode == OP_READ) begin
                            wb_adr_o <= {adr_hi_q, rx_data_i};
                            wb_we_o  <= 1'b0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= S_BUS;
                        end else begin
                            state <= S_DAT_HI;
                        end
                    end else if (gap_expired) begin
                        frame_err_o <= 1'b1;
                        state       <= S_CMD;
                    end
                end
                S_DAT_HI: begin
                    if (rx_dstrb_i) begin
                        dat_hi_q <= rx_data_i;
                        state    <= S_DAT_LO;
                    end else if (gap_expired) begin
                        frame_err_o <= 1'b1;
                        state       <= S_CMD;
                    end
                end
                S_DAT_LO: begin
                    if (rx_dstrb_i) begin
                        wb_adr_o <= {adr_hi_q, adr_lo_q};
                        wb_dat_o <= {dat_hi_q, rx_data_i};
                        wb_we_o  <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= S_BUS;
                    end else if (gap_expired) begin
                        frame_err_o <= 1'b1;
                        state       <= S_CMD;
                    end
                end
                // Ack is checked first so an ack in the timeout cycle succeeds
                S_BUS: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        status   <= ST_ACK;
                        if (opcode == OP_READ) begin
                            rd_data   <= wb_dat_i;
                            resp_last <= 2'd2;
                        end
                        state <= S_TX_LOAD;
                    end else if (bus_expired) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        wb_we_o     <= 1'b0;
                        status      <= ST_NAK;
                        frame_err_o <= 1'b1;
                        state       <= S_TX_LOAD;
                    end
                end
                S_TX_LOAD: begin
                    if (!tx_busy_i) begin
                        tx_data_o  <= resp_byte;
                        tx_dstrb_o <= 1'b1;
                        tx_hold    <= 2'd2;
                        state      <= S_TX_WAIT;
                    end
                end
                // Busy is not trusted in the strobe cycle or the one after it
                S_TX_WAIT: begin
                    if (tx_hold != 2'd0) begin
                        tx_hold <= tx_hold - 2'd1;
                    end else if (!tx_busy_i) begin
                        if (byte_idx == resp_last) begin
                            state <= S_CMD;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_TX_LOAD;
                        end
                    end
                end
                default: state <= S_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_bridge.sv
// Bench for serial_bus_bridge: directed frames plus random read/write traffic
// compared against a register-map model of the remote bus.
module tb_serial_bus_bridge;

    localparam int BUS_TO = 40;
    localparam int GAP_TO = 200;

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_dstrb_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_dstrb_o;
    logic        tx_busy_i = 1'b0;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i = 16'h0000;
    logic        wb_ack_i = 1'b0;
    logic        frame_err_o;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] tx_got[$];
    bus_t       bus_log[$];
    int         stab_viol = 0, bp_viol = 0, width_viol = 0, ferr_cnt = 0;
    int         cyc_len = 0, last_cyc_len = 0;
    logic       prev_dstrb = 1'b0, prev_busy = 1'b0, prev_cyc = 1'b0;
    bus_t       hold;

    bit [15:0]  slv_mem [0:65535];
    int         wait_cnt = 0;
    int         ack_delay = 3;
    bit         ack_en = 1'b1;
    bit         force_busy = 1'b0;
    int         busy_len = 2;
    int         busy_cnt = 0;

    logic [15:0] ref_mem [int];

    always #5 clk = ~clk;

    serial_bus_bridge #(.BUS_TIMEOUT(BUS_TO), .BYTE_TIMEOUT(GAP_TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data_i   (rx_data_i),
        .rx_dstrb_i  (rx_dstrb_i),
        .tx_data_o   (tx_data_o),
        .tx_dstrb_o  (tx_dstrb_o),
        .tx_busy_i   (tx_busy_i),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .frame_err_o (frame_err_o)
    );

    // Bus slave: memory-backed, acks after ack_delay cycles when enabled
    always @(posedge clk) begin
        wb_ack_i <= 1'b0;
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (ack_en && wait_cnt >= ack_delay) begin
                wb_ack_i <= 1'b1;
                wait_cnt <= 0;
                if (wb_we_o) slv_mem[wb_adr_o] <= wb_dat_o;
                else         wb_dat_i <= slv_mem[wb_adr_o];
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // UART transmitter: busy for busy_len cycles after each strobe, plus forced busy
    always @(posedge clk) begin
        prev_busy  <= tx_busy_i;
        prev_dstrb <= tx_dstrb_o;
        if (tx_dstrb_o) begin
            tx_got.push_back(tx_data_o);
            if (prev_busy)  bp_viol    <= bp_viol + 1;
            if (prev_dstrb) width_viol <= width_viol + 1;
            busy_cnt  <= busy_len;
            tx_busy_i <= (busy_len > 0) || force_busy;
        end else if (busy_cnt > 0) begin
            busy_cnt  <= busy_cnt - 1;
            tx_busy_i <= (busy_cnt > 1) || force_busy;
        end else begin
            tx_busy_i <= force_busy;
        end
    end

    // Bus and error monitor
    always @(posedge clk) begin
        prev_cyc <= wb_cyc_o;
        if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (wb_cyc_o && !prev_cyc) begin
            hold <= '{we: wb_we_o, adr: wb_adr_o, dat: wb_dat_o};
            bus_log.push_back('{we: wb_we_o, adr: wb_adr_o, dat: wb_dat_o});
        end else if (wb_cyc_o && (wb_we_o != hold.we || wb_adr_o != hold.adr ||
                     (hold.we && wb_dat_o != hold.dat))) begin
            stab_viol <= stab_viol + 1;
        end
        if (wb_cyc_o) begin
            cyc_len <= cyc_len + 1;
        end else if (cyc_len > 0) begin
            last_cyc_len <= cyc_len;
            cyc_len      <= 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_dstrb_i = 1'b1;
        tick(1);
        rx_dstrb_i = 1'b0;
        tick($urandom_range(0, 3));
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, input int len);
        logic [7:0] fb[5];
        fb = '{b0, b1, b2, b3, b4};
        for (int i = 0; i < len; i++) send_byte(fb[i]);
    endtask

    task automatic expect_resp(input string tag, input int base,
                               input logic [7:0] e0, e1, e2, input int n);
        logic [7:0] e[3];
        int t;
        e = '{e0, e1, e2};
        t = 0;
        while (tx_got.size() < base + n && t < 3000) begin
            tick(1);
            t++;
        end
        tick(busy_len + 20);
        check({tag, " resp_len"}, tx_got.size() - base, n);
        for (int i = 0; i < n; i++) begin
            check({tag, " resp_byte"},
                  (base + i < tx_got.size()) ? {56'd0, tx_got[base + i]} : 64'hx, e[i]);
        end
    endtask

    task automatic expect_bus(input string tag, input int base, input logic we,
                              input logic [15:0] adr, input logic [15:0] dat);
        check({tag, " bus_count"}, bus_log.size() - base, 1);
        if (bus_log.size() > base) begin
            check({tag, " bus_we"}, bus_log[base].we, we);
            check({tag, " bus_adr"}, bus_log[base].adr, adr);
            if (we) check({tag, " bus_dat"}, bus_log[base].dat, dat);
        end
    endtask

    task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d);
        int tb0, bb0;
        tb0 = tx_got.size();
        bb0 = bus_log.size();
        ref_mem[int'(a)] = d;
        send_frame(8'h01, a[15:8], a[7:0], d[15:8], d[7:0], 5);
        expect_resp(tag, tb0, 8'h06, 8'h00, 8'h00, 1);
        expect_bus(tag, bb0, 1'b1, a, d);
    endtask

    task automatic do_read(input string tag, input logic [15:0] a);
        int tb0, bb0;
        logic [15:0] d;
        tb0 = tx_got.size();
        bb0 = bus_log.size();
        d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
        send_frame(8'h02, a[15:8], a[7:0], 8'h00, 8'h00, 3);
        expect_resp(tag, tb0, 8'h06, d[15:8], d[7:0], 3);
        expect_bus(tag, bb0, 1'b0, a, 16'h0000);
    endtask

    initial begin
        int f0, tb0, bb0, t;
        logic [15:0] addrs[4];
        logic [15:0] a, d;
        addrs = '{16'h0100, 16'h0200, 16'h0300, 16'hA5A5};

        // Reset
        reset = 1'b1;
        tick(3);
        check("reset outputs",
              {tx_data_o, tx_dstrb_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, frame_err_o},
              '0);
        reset = 1'b0;
        tick(2);

        // Write 01 12 34 AB CD
        f0 = ferr_cnt;
        ack_delay = 3;
        do_write("write", 16'h1234, 16'hABCD);
        check("write ferr", ferr_cnt - f0, 0);
        check("tx_data hold", tx_data_o, 8'h06);

        // Read returning BEEF
        do_write("preload", 16'h0010, 16'hBEEF);
        do_read("read", 16'h0010);
        check("read width_viol", width_viol, 0);
        check("tx_data hold read", tx_data_o, 8'hEF);

        // Unknown opcode, then a valid frame
        f0 = ferr_cnt;
        tb0 = tx_got.size();
        bb0 = bus_log.size();
        send_byte(8'h7F);
        expect_resp("badop", tb0, 8'h15, 8'h00, 8'h00, 1);
        check("badop bus", bus_log.size() - bb0, 0);
        check("badop ferr", ferr_cnt - f0, 1);
        do_read("after badop", 16'h1234);

        // Bus timeout
        ack_en = 1'b0;
        f0 = ferr_cnt;
        tb0 = tx_got.size();
        send_frame(8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 3);
        expect_resp("bus_to", tb0, 8'h15, 8'h00, 8'h00, 1);
        check("bus_to cyc_len", last_cyc_len, BUS_TO);
        check("bus_to cyc low", wb_cyc_o, 1'b0);
        check("bus_to ferr", ferr_cnt - f0, 1);
        ack_en = 1'b1;

        // Byte gap
        f0 = ferr_cnt;
        tb0 = tx_got.size();
        bb0 = bus_log.size();
        send_frame(8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 2);
        tick(GAP_TO + 20);
        check("gap tx", tx_got.size() - tb0, 0);
        check("gap bus", bus_log.size() - bb0, 0);
        check("gap ferr", ferr_cnt - f0, 1);
        do_read("after gap", 16'h0010);

        // Backpressure
        busy_len = 50;
        force_busy = 1'b1;
        tb0 = tx_got.size();
        send_frame(8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 3);
        tick(50);
        check("bp held", tx_got.size() - tb0, 0);
        force_busy = 1'b0;
        expect_resp("bp", tb0, 8'h06, 8'hBE, 8'hEF, 3);
        check("bp violations", bp_viol, 0);
        busy_len = 2;

        // Random traffic against the register model
        for (int i = 0; i < 12; i++) begin
            a = addrs[$urandom_range(0, 3)];
            d = 16'($urandom);
            ack_delay = $urandom_range(0, 5);
            busy_len = $urandom_range(0, 4);
            if ($urandom_range(0, 1) == 1) do_write("rnd write", a, d);
            else                           do_read("rnd read", a);
        end
        busy_len = 2;

        // Reset during a bus cycle
        ack_en = 1'b0;
        tb0 = tx_got.size();
        send_frame(8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 3);
        t = 0;
        while (!wb_cyc_o && t < 50) begin
            tick(1);
            t++;
        end
        check("rst_bus cyc seen", wb_cyc_o, 1'b1);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("rst_bus cyc/stb", {wb_cyc_o, wb_stb_o}, 2'b00);
        reset = 1'b0;
        ack_en = 1'b1;
        tick(BUS_TO + 20);
        check("rst_bus no resp", tx_got.size() - tb0, 0);
        do_read("after reset", 16'h1234);

        check("stability", stab_viol, 0);
        check("strobe width", width_viol, 0);
        check("busy respected", bp_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
